mem_access_stage: RTL

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results straight to MEM/WB,
// runs loads/stores against the data RAM with a bounded wait for mem_ack,
// and flags timeouts and loads that are also stores.
//
// state  | meaning
// IDLE   | no RAM access pending; consume the EX/MEM instruction
// ACCESS | request held on the RAM port, waiting for mem_ack or timeout
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        wmem,
    input  logic        rmem,
    input  logic        wreg,
    input  logic        wpc,
    input  logic [1:0]  jmp,
    input  logic [31:0] alu_res,
    input  logic [31:0] st_data,
    input  logic [3:0]  dest,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_wreg,
    output logic        wb_wpc,
    output logic [1:0]  wb_jmp,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_dest,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_wb_valid;
    logic        r_wb_wreg;
    logic        r_wb_wpc;
    logic [1:0]  r_wb_jmp;
    logic [31:0] r_wb_data;
    logic [3:0]  r_wb_dest;
    logic        r_err;

    logic w_is_mem;
    logic w_illegal;
    logic w_timeout;

    assign w_is_mem  = rmem ^ wmem;
    assign w_illegal = rmem & wmem;
    // Timeout fires on the last allowed ACCESS cycle only if the ack is still missing
    assign w_timeout = (r_state == ACCESS) && !mem_ack && (r_cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid && w_is_mem) w_state_nxt = ACCESS;
            ACCESS:  if (mem_ack || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: stall towards EX/MEM and the RAM request
    always_comb begin
        stall   = 1'b0;
        mem_req = 1'b0;
        case (r_state)
            IDLE:    stall = in_valid && w_is_mem;
            ACCESS: begin
                mem_req = 1'b1;
                stall   = !mem_ack && !w_timeout;
            end
            default: ;
        endcase
    end

    // Access latches, wait counter and MEM/WB register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_wreg  <= 1'b0;
            r_wb_wpc   <= 1'b0;
            r_wb_jmp   <= 2'b00;
            r_wb_data  <= '0;
            r_wb_dest  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            if (r_state == IDLE) begin
                if (in_valid) begin
                    if (w_is_mem) begin
                        r_addr  <= alu_res;
                        r_wdata <= st_data;
                        r_we    <= wmem;
                        r_cnt   <= '0;
                    end else begin
                        // ALU op, or a load+store combination that is dropped
                        r_wb_valid <= 1'b1;
                        r_wb_wreg  <= wreg && !w_illegal;
                        r_wb_wpc   <= wpc;
                        r_wb_jmp   <= jmp;
                        r_wb_data  <= alu_res;
                        r_wb_dest  <= dest;
                        r_err      <= w_illegal;
                    end
                end
            end else begin
                if (mem_ack || w_timeout) begin
                    r_wb_valid <= 1'b1;
                    r_wb_wreg  <= mem_ack && !r_we && wreg;
                    r_wb_wpc   <= wpc;
                    r_wb_jmp   <= jmp;
                    r_wb_data  <= (mem_ack && !r_we) ? mem_rdata : alu_res;
                    r_wb_dest  <= dest;
                    r_err      <= w_timeout;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign wb_valid  = r_wb_valid;
    assign wb_wreg   = r_wb_wreg;
    assign wb_wpc    = r_wb_wpc;
    assign wb_jmp    = r_wb_jmp;
    assign wb_data   = r_wb_data;
    assign wb_dest   = r_wb_dest;
    assign err       = r_err;

endmodule
